// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seven_segment_pkg
// Description : Shared seven-segment definitions: segment bus type, the hex
//               glyph set {g,f,e,d,c,b,a} and a glyph-to-hex decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t c_BLANK   = 7'h00;
    localparam seg_t c_GLYPH_0 = 7'h3F;
    localparam seg_t c_GLYPH_1 = 7'h06;
    localparam seg_t c_GLYPH_2 = 7'h5B;
    localparam seg_t c_GLYPH_3 = 7'h4F;
    localparam seg_t c_GLYPH_4 = 7'h66;
    localparam seg_t c_GLYPH_5 = 7'h6D;
    localparam seg_t c_GLYPH_6 = 7'h7D;
    localparam seg_t c_GLYPH_7 = 7'h07;
    localparam seg_t c_GLYPH_8 = 7'h7F;
    localparam seg_t c_GLYPH_9 = 7'h6F;
    localparam seg_t c_GLYPH_A = 7'h77;
    localparam seg_t c_GLYPH_B = 7'h7C;
    localparam seg_t c_GLYPH_C = 7'h39;
    localparam seg_t c_GLYPH_D = 7'h5E;
    localparam seg_t c_GLYPH_E = 7'h79;
    localparam seg_t c_GLYPH_F = 7'h71;

    // Returns {err, digit}. Blank decodes to {0, 0}; callers treat blank
    // separately. Unknown non-blank patterns return err=1 with digit 0.
    function automatic logic [4:0] seg_decode(input seg_t seg);
        logic [4:0] v;
        case (seg)
            c_BLANK:   v = 5'h00;
            c_GLYPH_0: v = 5'h00;
            c_GLYPH_1: v = 5'h01;
            c_GLYPH_2: v = 5'h02;
            c_GLYPH_3: v = 5'h03;
            c_GLYPH_4: v = 5'h04;
            c_GLYPH_5: v = 5'h05;
            c_GLYPH_6: v = 5'h06;
            c_GLYPH_7: v = 5'h07;
            c_GLYPH_8: v = 5'h08;
            c_GLYPH_9: v = 5'h09;
            c_GLYPH_A: v = 5'h0A;
            c_GLYPH_B: v = 5'h0B;
            c_GLYPH_C: v = 5'h0C;
            c_GLYPH_D: v = 5'h0D;
            c_GLYPH_E: v = 5'h0E;
            c_GLYPH_F: v = 5'h0F;
            default:   v = 5'h10;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_reader_filter.sv
`default_nettype none
// ============================================================================
// Module      : seg_stability_filter
// Description : Two-flop synchronizer on the segment bus followed by a
//               candidate/run-length glitch filter. Emits a one-cycle strobe
//               on the cycle whose clock edge makes the candidate stable.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_stability_filter
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  seg_t i_seg,
    output seg_t o_cand,
    output logic o_load,
    output logic o_stable
);

    // Counter saturates at STABLE_CYCLES-1 (max 14), so 4 bits suffice.
    localparam logic [3:0] c_TH = 4'(STABLE_CYCLES - 1);

    seg_t       r_seg_s1;
    seg_t       r_seg_s2;
    seg_t       r_cand;
    logic [3:0] r_cnt;
    logic       w_load;
    logic       w_reach;

    assign w_load  = (r_seg_s2 != r_cand);
    assign w_reach = !w_load && (r_cnt == c_TH - 4'd1);

    // Synchronizer: free-running, independent of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= c_BLANK;
            r_seg_s2 <= c_BLANK;
        end else begin
            r_seg_s1 <= i_seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // Candidate capture and run-length count of identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= c_BLANK;
            r_cnt  <= 4'd0;
        end else if (i_ena) begin
            if (w_load) begin
                r_cand <= r_seg_s2;
                r_cnt  <= 4'd0;
            end else if (r_cnt < c_TH) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_cand   = r_cand;
    assign o_load   = i_ena && w_load;
    assign o_stable = i_ena && w_reach;

endmodule
`default_nettype wire

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_reader
// Description : Samples a seven-segment bus, glitch-filters it, decodes each
//               newly settled glyph to hex and offers it on a one-entry
//               valid/ready output slot with overflow and digit counting.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [6:0]       seg_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic             out_err,
    output logic             blank,
    output logic             overflow,
    output logic [CNT_W-1:0] digit_count
);

    localparam logic [1:0] c_S_SETTLING = 2'd0;
    localparam logic [1:0] c_S_STABLE   = 2'd1;
    localparam logic [1:0] c_S_HELD     = 2'd2;

    seg_t             w_cand;
    logic             w_load;
    logic             w_stable;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    seg_t             r_last;
    logic             r_blank;
    logic             r_valid;
    logic [3:0]       r_digit;
    logic             r_err;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;
    logic             w_is_stable;
    logic             w_cand_blank;
    logic             w_emit;
    logic [4:0]       w_decoded;

    seg_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_ena    (ena),
        .i_seg    (seg_in),
        .o_cand   (w_cand),
        .o_load   (w_load),
        .o_stable (w_stable)
    );

    assign w_is_stable  = (r_state == c_S_STABLE);
    assign w_cand_blank = (w_cand == c_BLANK);
    assign w_emit       = w_is_stable && !w_cand_blank && (w_cand != r_last);
    assign w_decoded    = seg_decode(w_cand);

    // FSM state register; frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_HELD;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a candidate change always restarts settling.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = c_S_SETTLING;
        end else begin
            case (r_state)
                c_S_SETTLING: if (w_stable) w_state_nxt = c_S_STABLE;
                c_S_STABLE:   w_state_nxt = c_S_HELD;
                default:      w_state_nxt = c_S_HELD;
            endcase
        end
    end

    // Last-reported pattern and blank level; a blank forgets the last digit
    // so the same glyph after a blank is reported again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= c_BLANK;
            r_blank <= 1'b1;
        end else if (ena) begin
            if (w_is_stable && w_cand_blank) begin
                r_last <= c_BLANK;
            end else if (w_emit) begin
                r_last <= w_cand;
            end
            if (w_load) begin
                r_blank <= 1'b0;
            end else if (w_is_stable && w_cand_blank) begin
                r_blank <= 1'b1;
            end
        end
    end

    // One-entry output slot; a full slot with no acceptance drops the new
    // digit and latches overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_digit    <= 4'd0;
            r_err      <= 1'b0;
            r_overflow <= 1'b0;
        end else if (ena) begin
            if (w_emit) begin
                if (!r_valid || out_ready) begin
                    r_valid <= 1'b1;
                    r_digit <= w_decoded[3:0];
                    r_err   <= w_decoded[4];
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Count error-free emits, including those dropped on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (ena && w_emit && !w_decoded[4]) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid   = r_valid;
    assign out_digit   = r_digit;
    assign out_err     = r_err;
    assign blank       = r_blank;
    assign overflow    = r_overflow;
    assign digit_count = r_count;

endmodule
`default_nettype wire
